// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide HI/LO controller: opcodes, FSM states
// and small opcode-decode helpers.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_muldiv(input logic [2:0] op);
        case (mdu_op_e'(op))
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_muldiv = 1'b1;
            default:                            is_muldiv = 1'b0;
        endcase
    endfunction

    function automatic logic is_signed(input logic [2:0] op);
        case (mdu_op_e'(op))
            OP_MULT, OP_DIV: is_signed = 1'b1;
            default:         is_signed = 1'b0;
        endcase
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        case (mdu_op_e'(op))
            OP_DIV, OP_DIVU: is_div = 1'b1;
            default:         is_div = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mdu_hilo_regs.sv
// Architectural HI/LO registers plus the result buffer that holds an MDU result
// until its instruction leaves EX.
module mdu_hilo_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic        buf_we,
    input  logic [63:0] buf_d,
    input  logic        commit,
    input  logic        clear,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [63:0] buf_r;

    // Result buffer capture and HI/LO update; watchdog clear outranks commit and moves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_r  <= 32'd0;
            lo_r  <= 32'd0;
            buf_r <= 64'd0;
        end else begin
            if (buf_we) begin
                buf_r <= buf_d;
            end
            if (clear) begin
                hi_r <= 32'd0;
                lo_r <= 32'd0;
            end else if (commit) begin
                hi_r <= buf_r[63:32];
                lo_r <= buf_r[31:0];
            end else begin
                if (hi_we) begin
                    hi_r <= wdata;
                end
                if (lo_we) begin
                    lo_r <= wdata;
                end
            end
        end
    end

    assign hi = hi_r;
    assign lo = lo_r;

endmodule

// File: rtl/mdu_hilo_ctrl.sv
// Execute-stage sequencer for the multi-cycle mul/div unit; commits HI/LO only when
// the owning instruction leaves EX unflushed, so flushes never corrupt HI/LO.
module mdu_hilo_ctrl
    import mdu_pkg::*;
#(
    parameter int MAX_CYCLES = 64,
    parameter int CNT_W      = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hold,
    input  logic        flush,
    output logic        stall,
    output logic        mdu_start,
    output logic        mdu_annul,
    output logic        mdu_signed,
    output logic        mdu_is_div,
    output logic [31:0] mdu_a,
    output logic [31:0] mdu_b,
    input  logic        mdu_ready,
    input  logic [63:0] mdu_result,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        timeout
);

    mdu_state_e        state_r;
    mdu_state_e        next_state_s;
    logic              start_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              timeout_r;
    logic [31:0]       a_r;
    logic [31:0]       b_r;
    logic              signed_r;
    logic              is_div_r;

    logic issue_s;
    logic stall_s;
    logic annul_s;
    logic buf_we_s;
    logic commit_s;
    logic clear_s;
    logic wd_fire_s;
    logic hi_we_s;
    logic lo_we_s;

    // Next-state and control decode; ready is ignored in the start cycle (start_r high).
    always_comb begin
        next_state_s = state_r;
        issue_s      = 1'b0;
        stall_s      = 1'b0;
        annul_s      = 1'b0;
        buf_we_s     = 1'b0;
        commit_s     = 1'b0;
        clear_s      = 1'b0;
        wd_fire_s    = 1'b0;
        hi_we_s      = 1'b0;
        lo_we_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (op_valid && !flush && is_muldiv(op)) begin
                    issue_s      = 1'b1;
                    stall_s      = 1'b1;
                    next_state_s = ST_BUSY;
                end else if (op_valid && !flush && !hold) begin
                    hi_we_s = (mdu_op_e'(op) == OP_MTHI);
                    lo_we_s = (mdu_op_e'(op) == OP_MTLO);
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                stall_s = 1'b1;
                if (flush) begin
                    annul_s      = 1'b1;
                    next_state_s = ST_IDLE;
                end else if (!start_r && mdu_ready) begin
                    buf_we_s     = 1'b1;
                    next_state_s = ST_DONE;
                end else if (cnt_r == CNT_W'(MAX_CYCLES)) begin
                    annul_s      = 1'b1;
                    wd_fire_s    = 1'b1;
                    clear_s      = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (flush) begin
                    next_state_s = ST_IDLE;
                end else if (!hold) begin
                    commit_s     = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, start pulse, operand latch, BUSY-cycle counter and sticky timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            start_r   <= 1'b0;
            cnt_r     <= CNT_W'(0);
            timeout_r <= 1'b0;
            a_r       <= 32'd0;
            b_r       <= 32'd0;
            signed_r  <= 1'b0;
            is_div_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            start_r <= issue_s;
            if (issue_s) begin
                a_r      <= src_a;
                b_r      <= src_b;
                signed_r <= is_signed(op);
                is_div_r <= is_div(op);
                cnt_r    <= CNT_W'(1);
            end else if (state_r == ST_BUSY) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (wd_fire_s) begin
                timeout_r <= 1'b1;
            end
        end
    end

    mdu_hilo_regs u_regs (
        .clk    (clk),
        .rst    (rst),
        .buf_we (buf_we_s),
        .buf_d  (mdu_result),
        .commit (commit_s),
        .clear  (clear_s),
        .hi_we  (hi_we_s),
        .lo_we  (lo_we_s),
        .wdata  (src_a),
        .hi     (hi),
        .lo     (lo)
    );

    assign stall      = stall_s;
    assign mdu_annul  = annul_s;
    assign mdu_start  = start_r;
    assign mdu_signed = signed_r;
    assign mdu_is_div = is_div_r;
    assign mdu_a      = a_r;
    assign mdu_b      = b_r;
    assign timeout    = timeout_r;

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Bench for mdu_hilo_ctrl: directed vector table, watchdog and reset sequences, then
// random instructions checked against an architectural HI/LO model.
module tb_mdu_hilo_ctrl;

    localparam logic [2:0] T_MULT  = 3'd1;
    localparam logic [2:0] T_MULTU = 3'd2;
    localparam logic [2:0] T_DIV   = 3'd3;
    localparam logic [2:0] T_DIVU  = 3'd4;
    localparam logic [2:0] T_MTHI  = 3'd5;
    localparam logic [2:0] T_MTLO  = 3'd6;

    logic        clk, rst, op_valid, hold, flush;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        stall, mdu_start, mdu_annul, mdu_signed, mdu_is_div;
    logic [31:0] mdu_a, mdu_b, hi, lo;
    logic        mdu_ready, timeout;
    logic [63:0] mdu_result;

    int checks = 0;
    int failures = 0;

    // mul/div unit model state
    int          mdu_k = 0;
    int          mdu_lat = 2;
    bit          mdu_never = 0;
    bit          annul_seen = 0;
    logic [63:0] mdu_res = 64'd0;

    // architectural expectation
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mdu_hilo_ctrl #(.MAX_CYCLES(64), .CNT_W(7)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .src_a(src_a), .src_b(src_b),
        .hold(hold), .flush(flush), .stall(stall), .mdu_start(mdu_start), .mdu_annul(mdu_annul),
        .mdu_signed(mdu_signed), .mdu_is_div(mdu_is_div), .mdu_a(mdu_a), .mdu_b(mdu_b),
        .mdu_ready(mdu_ready), .mdu_result(mdu_result), .hi(hi), .lo(lo), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_time_limit act=running exp=finished");
        $fatal(1, "time limit");
    end

    function automatic logic [63:0] ref_res(input logic d, input logic s,
                                            input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (!d) begin
            if (s) return 64'(sa * sb);
            else   return ua * ub;
        end
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (s) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // One clock; afterwards advance the mul/div unit model for the new cycle.
    task automatic cyc();
        annul_seen = mdu_annul;
        @(posedge clk);
        #1;
        if (!rst) mdu_k = 0;
        else if (mdu_start) begin
            mdu_k = 1;
            mdu_res = ref_res(mdu_is_div, mdu_signed, mdu_a, mdu_b);
        end else if (annul_seen) mdu_k = 0;
        else if (mdu_k > 0) mdu_k++;
        mdu_ready = !mdu_never && mdu_k > 0 && mdu_k == mdu_lat;
        mdu_result = mdu_ready ? mdu_res : {$urandom, $urandom};
        if (mdu_ready) mdu_k = 0;
    endtask

    // flush_at: 0 none, k>0 flush in BUSY cycle k, -1 flush in DONE (or on the MT cycle)
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int hold_n, input int flush_at);
        bit is_md, sgn, dv, fl, done;
        int k;
        logic [63:0] r;
        is_md = (o >= T_MULT && o <= T_DIVU);
        sgn = (o == T_MULT || o == T_DIV);
        dv = (o == T_DIV || o == T_DIVU);
        op_valid = 1'b1; op = o; src_a = a; src_b = b; flush = 1'b0;
        if (!is_md) begin
            for (int i = 0; i < hold_n; i++) begin
                hold = 1'b1;
                #1; chk("mt_stall", stall, 1'b0);
                cyc();
                chk("mt_held_hi", hi, exp_hi);
                chk("mt_held_lo", lo, exp_lo);
            end
            hold = 1'b0; flush = (flush_at != 0);
            #1; chk("mt_stall", stall, 1'b0);
            cyc();
            if (flush_at == 0) begin
                if (o == T_MTHI) exp_hi = a;
                else exp_lo = a;
            end
        end else begin
            mdu_lat = lat;
            hold = 1'($urandom % 2);
            #1; chk("issue_stall", stall, 1'b1);
            cyc();
            hold = 1'b0;
            k = 0; done = 0; fl = 0;
            while (!done && k < 200) begin
                k++;
                src_a = $urandom; src_b = $urandom;
                flush = (k == flush_at);
                #1;
                if (k == 1) begin
                    chk("start_pulse", mdu_start, 1'b1);
                    chk("mdu_a", mdu_a, a);
                    chk("mdu_b", mdu_b, b);
                    chk("mdu_signed", mdu_signed, sgn);
                    chk("mdu_is_div", mdu_is_div, dv);
                end else chk("start_once", mdu_start, 1'b0);
                chk("busy_stall", stall, 1'b1);
                chk("busy_annul", mdu_annul, flush);
                if (flush) begin fl = 1; done = 1; end
                else if (mdu_ready) done = 1;
                cyc();
            end
            if (!done) chk("busy_bound", 64'(k), 64'(0));
            flush = 1'b0;
            if (!fl) begin
                for (int i = 0; i < hold_n; i++) begin
                    hold = 1'b1;
                    #1;
                    chk("done_stall", stall, 1'b0);
                    chk("done_nostart", mdu_start, 1'b0);
                    cyc();
                    chk("done_held_hi", hi, exp_hi);
                    chk("done_held_lo", lo, exp_lo);
                end
                hold = 1'b0; flush = (flush_at < 0);
                #1;
                chk("done_stall", stall, 1'b0);
                chk("done_annul", mdu_annul, 1'b0);
                cyc();
                if (flush_at >= 0) begin
                    r = ref_res(dv, sgn, a, b);
                    exp_hi = r[63:32];
                    exp_lo = r[31:0];
                end
            end
        end
        op_valid = 1'b0; flush = 1'b0; hold = 1'b0;
        chk("sb_hi", hi, exp_hi);
        chk("sb_lo", lo, exp_lo);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          hold_n;
        int          flush_at;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int k;
        vecs[0]  = '{T_MTHI,  32'h11111111, 32'h0,        0, 0,  0, 32'h11111111, 32'h00000000};
        vecs[1]  = '{T_MTLO,  32'h22222222, 32'h0,        0, 0,  0, 32'h11111111, 32'h22222222};
        vecs[2]  = '{T_DIV,   32'd50,       32'd3,        4, 0,  2, 32'h11111111, 32'h22222222};
        vecs[3]  = '{T_MULT,  32'hFFFFFFFD, 32'd5,        4, 0,  0, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[4]  = '{T_DIVU,  32'd100,      32'd7,        3, 3,  0, 32'h00000002, 32'h0000000E};
        vecs[5]  = '{T_MTHI,  32'hDEADBEEF, 32'h0,        0, 0,  0, 32'hDEADBEEF, 32'h0000000E};
        vecs[6]  = '{T_MTLO,  32'h12345678, 32'h0,        0, 0,  0, 32'hDEADBEEF, 32'h12345678};
        vecs[7]  = '{T_MULTU, 32'hFFFFFFFF, 32'd2,        2, 0,  0, 32'h00000001, 32'hFFFFFFFE};
        vecs[8]  = '{T_DIV,   32'hFFFFFFF9, 32'd2,        5, 1, -1, 32'h00000001, 32'hFFFFFFFE};
        vecs[9]  = '{T_DIV,   32'hFFFFFFF9, 32'd2,        5, 0,  0, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[10] = '{T_DIVU,  32'h00001234, 32'd0,        2, 0,  0, 32'h00001234, 32'hFFFFFFFF};
        vecs[11] = '{T_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 6, 2,  0, 32'h3FFFFFFF, 32'h00000001};
        vecs[12] = '{T_MTHI,  32'hAAAA5555, 32'h0,        0, 2,  0, 32'hAAAA5555, 32'h00000001};
        vecs[13] = '{T_MTLO,  32'h0BADF00D, 32'h0,        0, 0, -1, 32'hAAAA5555, 32'h00000001};
        vecs[14] = '{T_MULTU, 32'h80000000, 32'd3,        3, 0,  0, 32'h00000001, 32'h80000000};

        rst = 1'b0; op_valid = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0;
        hold = 1'b0; flush = 1'b0; mdu_ready = 1'b0; mdu_result = 64'd0;
        cyc(); cyc();
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_start", mdu_start, 1'b0);
        chk("rst_annul", mdu_annul, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_mdu_a", mdu_a, 32'd0);
        rst = 1'b1;
        cyc();

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].hold_n, vecs[i].flush_at);
            chk("vec_hi", hi, vecs[i].ehi);
            chk("vec_lo", lo, vecs[i].elo);
            chk("vec_timeout", timeout, 1'b0);
        end

        // watchdog: unit never answers
        mdu_never = 1;
        op_valid = 1'b1; op = T_DIVU; src_a = 32'd9; src_b = 32'd3;
        #1; cyc();
        k = 0;
        while (k < 200) begin
            k++;
            #1;
            if (mdu_annul) break;
            cyc();
        end
        chk("wd_cycle", 64'(k), 64'd64);
        cyc();
        op_valid = 1'b0; mdu_never = 0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        chk("wd_timeout", timeout, 1'b1);
        chk("wd_hi", hi, 32'd0);
        chk("wd_lo", lo, 32'd0);
        #1; chk("wd_stall", stall, 1'b0);
        run_op(T_MTHI, 32'h5A5A5A5A, 32'd0, 0, 0, 0);
        chk("wd_sticky", timeout, 1'b1);

        // asynchronous reset in the middle of BUSY
        op_valid = 1'b1; op = T_MULT; src_a = 32'd3; src_b = 32'd4; mdu_lat = 20;
        #1; cyc(); cyc();
        #2; rst = 1'b0; op_valid = 1'b0;
        #1;
        chk("arst_stall", stall, 1'b0);
        chk("arst_start", mdu_start, 1'b0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_timeout", timeout, 1'b0);
        chk("arst_mdu_a", mdu_a, 32'd0);
        cyc();
        rst = 1'b1;
        exp_hi = 32'd0; exp_lo = 32'd0;
        cyc();
        run_op(T_MULTU, 32'hFFFFFFFF, 32'd2, 3, 0, 0);
        chk("arst_multu_hi", hi, 32'h00000001);
        chk("arst_multu_lo", lo, 32'hFFFFFFFE);

        // random instruction stream against the architectural model
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            int rl, rh, rf;
            ro = 3'(1 + $urandom % 6);
            ra = $urandom;
            rb = ($urandom % 8 == 0) ? 32'd0 : 32'($urandom);
            rl = 2 + $urandom % 6;
            rh = $urandom % 3;
            rf = 0;
            if ($urandom % 6 == 0) rf = ($urandom % 2 == 0) ? -1 : 1 + int'($urandom % rl);
            run_op(ro, ra, rb, rl, rh, rf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_hilo_ctrl.md
Name: mdu_hilo_ctrl

Overview:
- Execute-stage controller that sequences the multi-cycle multiply/divide unit and owns the architectural HI/LO registers.
- Issues one start per MULT/MULTU/DIV/DIVU, stalls the pipeline until the result is back, and buffers that result.
- Commits HI/LO only when the instruction leaves EX without a flush; writes MTHI/MTLO directly. An exception flush therefore never corrupts HI/LO.

Parameters:
- MAX_CYCLES, 64: watchdog limit on BUSY cycles before a forced annul.
- CNT_W, 7: width of the BUSY-cycle counter; must satisfy 2^CNT_W > MAX_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- op_valid  in  1  a valid MDU-class instruction is in EX.
- op  in  3  operation code (package encoding).
- src_a  in  32  rs operand.
- src_b  in  32  rt operand.
- hold  in  1  external stall: EX cannot advance this cycle.
- flush  in  1  exception/branch flush of EX.
- stall  out  1  stall request to the hazard unit.
- mdu_start  out  1  one-cycle start pulse to the mul/div unit.
- mdu_annul  out  1  one-cycle abort to the mul/div unit.
- mdu_signed  out  1  signed operation.
- mdu_is_div  out  1  1 = divide, 0 = multiply.
- mdu_a  out  32  latched operand A.
- mdu_b  out  32  latched operand B.
- mdu_ready  in  1  result valid from the mul/div unit.
- mdu_result  in  64  {hi, lo} result.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.
- timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; hi, lo, mdu_a, mdu_b, result buffer, counter and timeout all cleared; mdu_start=mdu_annul=0.
- State machine: IDLE, BUSY, DONE.
- IDLE:
  - op_valid & mul/div & !flush: latch src_a/src_b into mdu_a/mdu_b; latch signed and is_div; go BUSY. The transition ignores hold.
  - op_valid & MTHI/MTLO & !hold & !flush: write hi or lo with src_a at that edge. No stall.
  - Any op_valid with flush: no action.
- BUSY:
  - mdu_start=1 in the first BUSY cycle only (registered pulse).
  - mdu_ready is ignored in the start cycle. From the next cycle on, mdu_ready=1 captures mdu_result into the buffer and moves to DONE.
  - Counter increments each BUSY cycle.
- DONE:
  - !hold & !flush: hi<=buf[63:32], lo<=buf[31:0]; go IDLE.
  - flush: discard the buffer, no HI/LO write; go IDLE.
  - hold & !flush: stay in DONE and keep the buffer.
- stall:
  - Combinational: 1 in BUSY.
  - 1 in IDLE when op_valid & mul/div & !flush.
  - 0 in DONE. DONE blocks re-issue of the same instruction while it is still held in EX.
- Flush in BUSY: mdu_annul=1 for one cycle (combinational). Go IDLE; any mdu_ready in that cycle is ignored.
- Watchdog: when the counter reaches MAX_CYCLES in BUSY, set timeout (sticky until reset), pulse mdu_annul, write hi=lo=0, go IDLE.
- Operand bypass: mdu_a/mdu_b stay stable from the IDLE->BUSY edge until the next issue.
- MFHI/MFLO read hi/lo directly. A write in the same cycle is visible on the following cycle; the forwarding unit covers this case.
- Boundary: divide-by-zero results are passed through unchanged (the MDU defines them).

Decomposition:
- Shared package mdu_pkg holds:
  - op encodings: OP_NONE=0, OP_MULT=1, OP_MULTU=2, OP_DIV=3, OP_DIVU=4, OP_MTHI=5, OP_MTLO=6;
  - state encodings;
  - helper constants is_muldiv and is_signed.
- One sub-module is natural: mdu_hilo_regs, holding HI/LO and the result buffer with its write-enable muxing. The FSM and watchdog stay in the top block.

Test Plan:
- MULT -3 × 5, MDU ready after 4 cycles, hold=0 -> mdu_start pulses once; stall=1 for 5 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFF1 after the DONE edge.
- DIVU 100/7 with hold=1 for 3 cycles in DONE -> no second mdu_start; hi/lo unchanged until hold drops, then hi=2, lo=14.
- DIV started, flush on 2nd BUSY cycle -> mdu_annul pulses once; state IDLE; hi/lo keep prior values 0x11111111/0x22222222.
- MTHI 0xDEADBEEF then MTLO 0x12345678 back-to-back, no hold -> hi=0xDEADBEEF and lo=0x12345678 one edge each; stall stays 0.
- MDU never asserts ready, MAX_CYCLES=64 -> annul at cycle 64; timeout=1; hi=lo=0.
- rst driven low mid-BUSY -> all outputs reset immediately, without a clock edge; after release, a new MULTU 0xFFFFFFFF×2 gives hi=1, lo=0xFFFFFFFE.
